// File: rtl/pingpong_frame_buffer.sv
// Double-buffered frame store: front bank feeds scan-out, back bank takes draw writes, built-in clear sequencer.
// Optional macro PINGPONG_FB_READ_REG_EN adds an output register after the bank read mux (read latency 2).
module pingpong_frame_buffer #(
    parameter int                    DATA_WIDTH  = 1,
    parameter int                    DEPTH       = 1024,
    parameter int                    ADDR_WIDTH  = 10,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_ready,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  swap_req,
    output logic                  swap_ack,
    input  logic                  clear_req,
    output logic                  clear_done,
    output logic                  front_sel
);

    // state    | meaning
    // ST_INIT  | wipe both banks after reset, one address per cycle
    // ST_IDLE  | back bank accepts draw writes; swap/clear requests accepted here
    // ST_CLEAR | wipe the back bank only; front bank keeps serving reads
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_front_sel;
    logic                  w_front_sel_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;
    logic                  w_clr_last;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_we0;
    logic                  w_we1;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [IDX_W-1:0]      w_rd_idx;
    logic                  w_write_ready;
    logic                  w_swap_ack;
    logic                  w_clear_done;

    logic [DATA_WIDTH-1:0] r_bank0 [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_bank1 [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rd0;
    logic [DATA_WIDTH-1:0] r_rd1;
    logic                  r_rd_sel;
    logic                  r_rd_in_range;
    logic [DATA_WIDTH-1:0] w_rd_mux;

    assign w_clr_last    = (r_clr_cnt == LAST_ADDR);
    assign w_wr_in_range = ({1'b0, write_addr} < DEPTH_X);
    assign w_rd_in_range = ({1'b0, read_addr} < DEPTH_X);
    assign w_rd_idx      = read_addr[IDX_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_front_sel <= 1'b0;
            r_clr_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_front_sel <= w_front_sel_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
        end
    end

    // Write port is shared between the clear sequencer and draw writes; only one is active per state.
    always_comb begin
        w_state_nxt     = r_state;
        w_front_sel_nxt = r_front_sel;
        w_clr_cnt_nxt   = r_clr_cnt;
        w_we0           = 1'b0;
        w_we1           = 1'b0;
        w_wr_idx        = r_clr_cnt[IDX_W-1:0];
        w_wr_data       = CLEAR_VALUE;
        w_write_ready   = 1'b0;
        w_swap_ack      = 1'b0;
        w_clear_done    = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_we0 = 1'b1;
                w_we1 = 1'b1;
                if (w_clr_last) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr_cnt_nxt = '0;
                    w_clear_done  = 1'b1;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                w_write_ready = 1'b1;
                w_clr_cnt_nxt = '0;
                if (we && w_wr_in_range) begin
                    w_wr_idx  = write_addr[IDX_W-1:0];
                    w_wr_data = write_data;
                    w_we0     = r_front_sel;
                    w_we1     = ~r_front_sel;
                end
                if (swap_req) begin
                    w_swap_ack      = 1'b1;
                    w_front_sel_nxt = ~r_front_sel;
                    w_state_nxt     = ST_CLEAR;
                end else if (clear_req) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_we0 = r_front_sel;
                w_we1 = ~r_front_sel;
                if (w_clr_last) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr_cnt_nxt = '0;
                    w_clear_done  = 1'b1;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt   = ST_INIT;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we0) r_bank0[w_wr_idx] <= w_wr_data;
        if (w_we1) r_bank1[w_wr_idx] <= w_wr_data;
        r_rd0 <= r_bank0[w_rd_idx];
        r_rd1 <= r_bank1[w_rd_idx];
    end

    // Bank select and range flag are captured with the address so a swap on the same edge cannot tear the read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_sel      <= 1'b0;
            r_rd_in_range <= 1'b0;
        end else begin
            r_rd_sel      <= r_front_sel;
            r_rd_in_range <= w_rd_in_range;
        end
    end

    assign w_rd_mux = !r_rd_in_range ? CLEAR_VALUE : (r_rd_sel ? r_rd1 : r_rd0);

`ifdef PINGPONG_FB_READ_REG_EN
    logic [DATA_WIDTH-1:0] r_read_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_read_pipe <= CLEAR_VALUE;
        else       r_read_pipe <= w_rd_mux;
    end

    assign read_data = r_read_pipe;
`else
    assign read_data = w_rd_mux;
`endif

    assign write_ready = w_write_ready;
    assign swap_ack    = w_swap_ack;
    assign clear_done  = w_clear_done;
    assign front_sel   = r_front_sel;

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Bench for pingpong_frame_buffer: write table, read scoreboard with exact-latency checks, hand-written swap/clear/reset sequences.
`timescale 1ns/1ps
module tb_pingpong_frame_buffer;

    localparam int            DW    = 4;
    localparam int            DEPTH = 16;
    localparam int            AW    = 5;
    localparam logic [DW-1:0] CV    = '0;
`ifdef PINGPONG_FB_READ_REG_EN
    localparam int            RL    = 2;
`else
    localparam int            RL    = 1;
`endif

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          we         = 1'b0;
    logic [AW-1:0] write_addr = '0;
    logic [DW-1:0] write_data = '0;
    logic [AW-1:0] read_addr  = '0;
    logic          swap_req   = 1'b0;
    logic          clear_req  = 1'b0;
    logic          write_ready;
    logic          swap_ack;
    logic          clear_done;
    logic          front_sel;
    logic [DW-1:0] read_data;

    pingpong_frame_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .CLEAR_VALUE(CV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .write_addr (write_addr),
        .write_data (write_data),
        .write_ready(write_ready),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .clear_req  (clear_req),
        .clear_done (clear_done),
        .front_sel  (front_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } rd_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_vec_t;

    rd_exp_t       sb_q[$];
    wr_vec_t       wr_tab[8];
    logic [DW-1:0] m_bank[2][DEPTH];
    logic          m_front;
    int            cyc;
    int            n_cmp;
    int            n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (int'(a) >= DEPTH) return CV;
        return m_bank[m_front][a[3:0]];
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (int'(a) < DEPTH) m_bank[~m_front][a[3:0]] = d;
    endtask

    task automatic model_zero(input logic b);
        for (int j = 0; j < DEPTH; j++) m_bank[b][4'(j)] = CV;
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        cyc++;
    endtask

    task automatic settle();
        rd_exp_t e;
        #1;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            chk($sformatf("read_data[%0d]", e.addr), 32'(read_data), 32'(e.exp));
        end
    endtask

    task automatic do_cycle(input logic i_we, input logic [AW-1:0] i_wa, input logic [DW-1:0] i_wd,
                            input logic i_rd, input logic [AW-1:0] i_ra,
                            input logic i_sreq, input logic i_creq);
        begin_cycle();
        we         = i_we;
        write_addr = i_wa;
        write_data = i_wd;
        read_addr  = i_ra;
        swap_req   = i_sreq;
        clear_req  = i_creq;
        if (i_rd) sb_q.push_back('{cyc + RL, i_ra, model_rd(i_ra)});
        settle();
    endtask

    task automatic release_and_init();
        for (int i = 0; i < DEPTH; i++) begin
            begin_cycle();
            if (i == 0) reset = 1'b0;
            we = 1'b0; swap_req = 1'b0; clear_req = 1'b0;
            settle();
            chk("init_write_ready", 32'(write_ready), 0);
            chk("init_clear_done", 32'(clear_done), (i == DEPTH - 1) ? 1 : 0);
        end
        do_cycle(0, '0, '0, 0, '0, 0, 0);
        chk("init_done_write_ready", 32'(write_ready), 1);
        chk("init_done_clear_done", 32'(clear_done), 0);
        m_front = 1'b0;
        model_zero(0);
        model_zero(1);
    endtask

    // One CLEAR pass: reads the front bank, checks ready/ack/done and the front index every cycle.
    task automatic clear_pass(input string tag, input logic exp_front, input logic wr_attempt, input int sreq_from);
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(wr_attempt, 5'd3, 4'h1, 1, AW'(i), (sreq_from >= 0 && i >= sreq_from), 0);
            chk({tag, "_write_ready"}, 32'(write_ready), 0);
            chk({tag, "_swap_ack"}, 32'(swap_ack), 0);
            chk({tag, "_clear_done"}, 32'(clear_done), (i == DEPTH - 1) ? 1 : 0);
            chk({tag, "_front_sel"}, 32'(front_sel), 32'(exp_front));
        end
    endtask

    task automatic swap_cycle(input string tag, input logic i_we, input logic [AW-1:0] i_wa,
                              input logic [DW-1:0] i_wd, input logic [AW-1:0] i_ra, input logic i_creq);
        do_cycle(i_we, i_wa, i_wd, 1, i_ra, 1, i_creq);
        chk({tag, "_swap_ack"}, 32'(swap_ack), 1);
        chk({tag, "_write_ready"}, 32'(write_ready), 1);
        if (i_we) model_write(i_wa, i_wd);
        model_zero(m_front);
        m_front = ~m_front;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; n_cmp = 0; n_bad = 0; m_front = 1'b0;
        model_zero(0);
        model_zero(1);
        wr_tab = '{'{5'd5, 4'h1}, '{5'd20, 4'h1}, '{5'd0, 4'hA}, '{5'd15, 4'h3},
                   '{5'd16, 4'hF}, '{5'd31, 4'h7}, '{5'd7, 4'h5}, '{5'd7, 4'h6}};

        repeat (3) do_cycle(0, '0, '0, 0, '0, 0, 0);
        chk("rst_write_ready", 32'(write_ready), 0);
        chk("rst_swap_ack", 32'(swap_ack), 0);
        chk("rst_clear_done", 32'(clear_done), 0);
        chk("rst_front_sel", 32'(front_sel), 0);
        chk("rst_read_data", 32'(read_data), 32'(CV));

        release_and_init();

        for (int a = 0; a < 2 * DEPTH; a++) do_cycle(0, '0, '0, 1, AW'(a), 0, 0);

        // Table of draw writes into back bank1, including out-of-range addresses and an overwrite.
        for (int i = 0; i < 8; i++) begin
            do_cycle(1, wr_tab[i].addr, wr_tab[i].data, 1, wr_tab[i].addr, 0, 0);
            chk("tab_write_ready", 32'(write_ready), 1);
            model_write(wr_tab[i].addr, wr_tab[i].data);
        end
        swap_cycle("swap1", 1, 5'd9, 4'hC, 5'd5, 0);
        chk("swap1_front_before_edge", 32'(front_sel), 0);

        // Drawing attempts during CLEAR are dropped; swap_req raised mid-clear stays pending.
        clear_pass("clr1", 1, 1, 4);
        swap_cycle("swap2", 0, '0, '0, 5'd21, 0);
        clear_pass("clr2", 0, 0, -1);

        do_cycle(1, 5'd2, 4'h9, 0, '0, 0, 0);
        model_write(5'd2, 4'h9);
        swap_cycle("swap_prio", 0, '0, '0, 5'd2, 1);
        clear_pass("clr3", 1, 0, -1);

        do_cycle(1, 5'd4, 4'hE, 0, '0, 0, 0);
        model_write(5'd4, 4'hE);
        do_cycle(0, '0, '0, 0, '0, 0, 1);
        chk("clrreq_swap_ack", 32'(swap_ack), 0);
        chk("clrreq_write_ready", 32'(write_ready), 1);
        model_zero(~m_front);
        clear_pass("clr4", 1, 0, -1);
        swap_cycle("swap3", 0, '0, '0, '0, 0);
        clear_pass("clr5", 0, 0, -1);

        // Reset while the clear counter sits at 7, with nonzero data on read_data.
        do_cycle(1, 5'd6, 4'hB, 0, '0, 0, 0);
        model_write(5'd6, 4'hB);
        swap_cycle("swap4", 0, '0, '0, 5'd6, 0);
        for (int i = 0; i < 8; i++) begin
            do_cycle(0, '0, '0, 1, 5'd6, (i == 7), 0);
            chk("pre_rst_front_sel", 32'(front_sel), 1);
        end
        chk("pre_rst_read_data", 32'(read_data), 32'hB);
        #2;
        reset    = 1'b1;
        swap_req = 1'b0;
        #1;
        sb_q.delete();
        chk("mid_rst_write_ready", 32'(write_ready), 0);
        chk("mid_rst_swap_ack", 32'(swap_ack), 0);
        chk("mid_rst_clear_done", 32'(clear_done), 0);
        chk("mid_rst_front_sel", 32'(front_sel), 0);
        chk("mid_rst_read_data", 32'(read_data), 32'(CV));
        do_cycle(0, '0, '0, 0, '0, 0, 0);
        chk("mid_rst_held_ready", 32'(write_ready), 0);
        release_and_init();
        chk("post_init_front_sel", 32'(front_sel), 0);

        // Read-after-swap latency: a single read of addr 5 framed by reads of addr 6.
        do_cycle(1, 5'd5, 4'h1, 1, 5'd6, 0, 0);
        model_write(5'd5, 4'h1);
        swap_cycle("swap5", 0, '0, '0, 5'd6, 0);
        do_cycle(0, '0, '0, 1, 5'd6, 0, 0);
        do_cycle(0, '0, '0, 1, 5'd5, 0, 0);
        do_cycle(0, '0, '0, 1, 5'd6, 0, 0);
        do_cycle(0, '0, '0, 1, 5'd20, 0, 0);
        repeat (RL + 1) begin
            do_cycle(0, '0, '0, 0, '0, 0, 0);
            chk("final_write_ready", 32'(write_ready), 0);
        end
        chk("sb_drained", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pingpong_frame_buffer.md
Name: pingpong_frame_buffer

Overview:
- Parametrised double-buffered (ping-pong) frame store for the boid renderer.
- Two banks, each DEPTH words of DATA_WIDTH bits:
  - Front bank serves the display read port.
  - Back bank accepts drawing writes.
- On a swap handshake, the banks exchange roles. A built-in clear sequencer then wipes the new back bank to CLEAR_VALUE before drawing may resume.
- Sits between the boid draw engine (write side) and the VGA scan-out (read side).

Parameters:
- DATA_WIDTH, 1, bits per pixel word.
- DEPTH, 1024, words per bank; need not be a power of 2.
- ADDR_WIDTH, 10, address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- CLEAR_VALUE, 0, DATA_WIDTH-bit word written by the clear sequencer.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- we  input  1  draw write request to back bank
- write_addr  input  ADDR_WIDTH  back-bank write address
- write_data  input  DATA_WIDTH  back-bank write data
- write_ready  output  1  high when back bank accepts writes
- read_addr  input  ADDR_WIDTH  front-bank read address
- read_data  output  DATA_WIDTH  front-bank read data
- swap_req  input  1  level request to exchange banks; held until swap_ack
- swap_ack  output  1  one-cycle pulse, swap accepted
- clear_req  input  1  level request to clear back bank without swapping
- clear_done  output  1  one-cycle pulse when any clear pass completes
- front_sel  output  1  index of current front bank (0 = bank0)

Behaviour:
- Clock and reset: clk; reset is asynchronous, active-high.
- Storage:
  - Each bank is a simple dual-port RAM: one write port, one read port.
  - The front read and the back write/clear proceed in the same cycle.
- Reset values:
  - front_sel=0, state=INIT, clear counter=0.
  - write_ready=0, swap_ack=0, clear_done=0, read_data=CLEAR_VALUE.
- States:
  - INIT: clears both banks in parallel, addresses 0..DEPTH-1, one per cycle. After address DEPTH-1 is written, go to IDLE next cycle and pulse clear_done. Total DEPTH cycles after reset release.
  - IDLE:
    - write_ready=1.
    - A write is committed to the back bank when we=1 and write_addr<DEPTH.
    - swap_req=1: front_sel toggles at the edge, swap_ack pulses, go to CLEAR. The bank being cleared is the old front.
    - Else clear_req=1: go to CLEAR on the current back bank with no toggle.
    - swap_req has priority over clear_req.
  - CLEAR:
    - write_ready=0.
    - Counter walks 0..DEPTH-1 writing CLEAR_VALUE to the back bank.
    - After DEPTH-1, go to IDLE and pulse clear_done. Counter returns to 0.
- Write rules:
  - Writes with we=1 while write_ready=0 are dropped; no queueing.
  - write_addr>=DEPTH is dropped in any state.
  - A write in the same cycle a swap is accepted is committed to the old back bank, which becomes the front bank.
- Swap and clear request rules:
  - swap_req or clear_req asserted during INIT or CLEAR is held pending. It is accepted in the first IDLE cycle, i.e. the cycle after clear_done.
  - swap_ack never asserts outside IDLE.
- Read rules:
  - Latency 1 cycle.
  - read_addr is sampled at edge k, together with the front_sel value in effect before edge k. read_data presents that word after edge k.
  - read_addr>=DEPTH returns CLEAR_VALUE.
  - The front bank is never written, so reads are coherent across a clear.
- Reset mid-operation: abort any clear and restart INIT from address 0. Pending requests are discarded.
- Counter width is ADDR_WIDTH. The terminal compare is against DEPTH-1, not wrap-around.

Optional Feature:
- Macro: PINGPONG_FB_READ_REG_EN.
- Defined:
  - Adds an output register after the bank read mux; read latency is 2 cycles.
  - The front_sel used for the read is still the value at address-sample time.
  - The extra register resets to CLEAR_VALUE.
- Undefined: read latency 1 cycle, as above.

Test Plan:
- Release reset, DEPTH=16, CLEAR_VALUE=0:
  - write_ready=0 for 16 cycles, then clear_done pulses once and write_ready=1.
  - Reads of all addresses in both banks return 0.
- IDLE, write 1 to addr 5 and 1 to addr 20 (>=DEPTH), then swap_req:
  - swap_ack pulses one cycle and front_sel goes to 1.
  - Reading addr 5 returns 1 one cycle later; reading addr 20 returns 0.
  - write_ready=0 for 16 cycles.
- swap_req held high during CLEAR: no swap_ack until the cycle after clear_done.
  - Then swap_ack fires and front_sel toggles back to 0.
- swap_req and clear_req both high in IDLE: swap taken (front_sel toggles, swap_ack=1).
  - Then clear_req alone later: CLEAR with front_sel unchanged, clear_done after 16 cycles, no swap_ack.
- Writes with we=1 during CLEAR to addr 3 value 1: dropped.
  - After the next swap, reading addr 3 returns 0.
- Assert reset at clear counter=7: outputs return to reset values immediately.
  - The full 16-cycle INIT reruns after release.
  - With PINGPONG_FB_READ_REG_EN defined, the read-after-swap check sees data at 2-cycle latency.
